gon_gather_bus: RTL and testbench

//  Parametrised N-to-1 gather bus for the GON (global output network) of one PE-array row.

---
 rtl/gon_gather_bus_if.sv | 23 ++
 rtl/gon_gather_bus.sv | 104 ++++++++++
 tb/tb_gon_gather_bus.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gon_gather_bus_if.sv
// Handshake bundle between the GON masters of one PE-array row, the gather bus and its slave.
// The master modport is the environment (PE masters plus sink); the slave modport is the gather bus.
interface gon_gather_bus_if #(
   parameter int NUMS_MASTER = 8,
   parameter int DATA_W      = 16
);
   logic [NUMS_MASTER-1:0]        master_valid;
   logic [NUMS_MASTER*DATA_W-1:0] master_data;
   logic [NUMS_MASTER-1:0]        master_ready;
   logic                          slave_valid;
   logic [DATA_W-1:0]             slave_data;
   logic                          slave_ready;

   modport master (
      output master_valid, master_data, slave_ready,
      input  master_ready, slave_valid, slave_data
   );

   modport slave (
      input  master_valid, master_data, slave_ready,
      output master_ready, slave_valid, slave_data
   );
endinterface

// File: rtl/gon_gather_bus.sv
// N-to-1 GON gather bus: tag-matched masters arbitrate (fixed or round-robin) for one slave port,
// with scan-loaded per-master IDs and an optional one-entry output register.
module gon_gather_bus #(
   parameter int NUMS_MASTER = 8,
   parameter int ID_SIZE     = 4,
   parameter int DATA_W      = 16,
   parameter int ARB_MODE    = 0,
   parameter int OUT_REG     = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ID_SIZE-1:0] tag,
   input  logic               set_id,
   input  logic [ID_SIZE-1:0] ID_scan_in,
   output logic [ID_SIZE-1:0] ID_scan_out,
   gon_gather_bus_if.slave    bus
);
   localparam int PTR_W = (NUMS_MASTER > 1) ? $clog2(NUMS_MASTER) : 1;

   logic [ID_SIZE-1:0]     id_q [NUMS_MASTER];
   logic [ID_SIZE-1:0]     id_d [NUMS_MASTER];
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic                   full_q, full_d;
   logic [DATA_W-1:0]      data_q, data_d;

   logic [NUMS_MASTER-1:0] match, req, grant, ready;
   logic [PTR_W-1:0]       grant_idx;
   logic [DATA_W-1:0]      grant_data;
   logic                   found, accept, push;
   int                     idx;

   // Requests are suppressed entirely while the ID chain is being scanned.
   always_comb begin
      match = '0;
      for (int i = 0; i < NUMS_MASTER; i++) match[i] = (id_q[i] == tag);
      req = bus.master_valid & match & {NUMS_MASTER{!set_id}};
   end

   always_comb begin
      grant      = '0;
      grant_idx  = '0;
      grant_data = '0;
      found      = 1'b0;
      idx        = 0;
      for (int k = 0; k < NUMS_MASTER; k++) begin
         idx = (ARB_MODE == 0) ? k : (int'(ptr_q) + k) % NUMS_MASTER;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = PTR_W'(idx);
         end
      end
      for (int i = 0; i < NUMS_MASTER; i++)
         if (grant[i]) grant_data = bus.master_data[i*DATA_W +: DATA_W];
   end

   assign accept = (OUT_REG != 0) ? (!full_q || bus.slave_ready) : bus.slave_ready;
   assign push   = found && accept;

   // Unmatched masters are always ready so their beats are silently dropped.
   always_comb begin
      ready = '0;
      for (int i = 0; i < NUMS_MASTER; i++)
         ready[i] = !set_id && (match[i] ? (grant[i] && accept) : 1'b1);
   end

   always_comb begin
      for (int i = 0; i < NUMS_MASTER; i++) id_d[i] = id_q[i];
      if (set_id) begin
         id_d[0] = ID_scan_in;
         for (int i = 1; i < NUMS_MASTER; i++) id_d[i] = id_q[i-1];
      end
      ptr_d = ptr_q;
      if (ARB_MODE != 0 && push)
         ptr_d = (grant_idx == PTR_W'(NUMS_MASTER - 1)) ? '0 : grant_idx + PTR_W'(1);
      full_d = 1'b0;
      data_d = data_q;
      if (OUT_REG != 0) begin
         full_d = push || (full_q && !bus.slave_ready);
         if (push) data_d = grant_data;
      end
   end

   // NOTE: the ID chain is only a few flops and must read zero after reset, so it is reset with the rest.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUMS_MASTER; i++) id_q[i] <= '0;
         ptr_q  <= '0;
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values (the scan shift depends on it).
         id_q   <= id_d;
         ptr_q  <= ptr_d;
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign bus.master_ready = ready;
   assign bus.slave_valid  = (OUT_REG != 0) ? full_q : (|req);
   assign bus.slave_data   = (OUT_REG != 0) ? data_q : grant_data;
   assign ID_scan_out      = id_q[NUMS_MASTER-1];
endmodule

// File: tb/tb_gon_gather_bus.sv
// Self-checking bench: fixed-priority/registered (8 masters), round-robin/registered (4 masters)
// and round-robin/pass-through (4 masters) instances of gon_gather_bus.
module tb_gon_gather_bus;
   localparam int IDW = 4;
   localparam int DW  = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] sb[$];

   logic [IDW-1:0] f_tag, f_scan_in, f_scan_out;
   logic           f_set_id;
   gon_gather_bus_if #(.NUMS_MASTER(8), .DATA_W(DW)) f_bus ();
   gon_gather_bus #(.NUMS_MASTER(8), .ID_SIZE(IDW), .DATA_W(DW), .ARB_MODE(0), .OUT_REG(1)) dut_fix (
      .clk(clk), .rst(rst), .tag(f_tag), .set_id(f_set_id),
      .ID_scan_in(f_scan_in), .ID_scan_out(f_scan_out), .bus(f_bus));

   logic [IDW-1:0] r_tag, r_scan_in, r_scan_out;
   logic           r_set_id;
   gon_gather_bus_if #(.NUMS_MASTER(4), .DATA_W(DW)) r_bus ();
   gon_gather_bus #(.NUMS_MASTER(4), .ID_SIZE(IDW), .DATA_W(DW), .ARB_MODE(1), .OUT_REG(1)) dut_rr (
      .clk(clk), .rst(rst), .tag(r_tag), .set_id(r_set_id),
      .ID_scan_in(r_scan_in), .ID_scan_out(r_scan_out), .bus(r_bus));

   logic [IDW-1:0] c_tag, c_scan_in, c_scan_out;
   logic           c_set_id;
   gon_gather_bus_if #(.NUMS_MASTER(4), .DATA_W(DW)) c_bus ();
   gon_gather_bus #(.NUMS_MASTER(4), .ID_SIZE(IDW), .DATA_W(DW), .ARB_MODE(1), .OUT_REG(0)) dut_cmb (
      .clk(clk), .rst(rst), .tag(c_tag), .set_id(c_set_id),
      .ID_scan_in(c_scan_in), .ID_scan_out(c_scan_out), .bus(c_bus));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      f_tag = '0; f_scan_in = '0; f_set_id = 1'b0;
      r_tag = '0; r_scan_in = '0; r_set_id = 1'b0;
      c_tag = '0; c_scan_in = '0; c_set_id = 1'b0;
      f_bus.master_valid = '0; f_bus.master_data = '0; f_bus.slave_ready = 1'b0;
      r_bus.master_valid = '0; r_bus.master_data = '0; r_bus.slave_ready = 1'b0;
      c_bus.master_valid = '0; c_bus.master_data = '0; c_bus.slave_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (f_bus.slave_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", f_bus.slave_valid); end
      checks++; if (f_bus.slave_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0000", f_bus.slave_data); end
      checks++; if (f_scan_out !== '0) begin errors++; $display("FAIL reset_scan_out: got %h want 0", f_scan_out); end
      checks++; if (r_bus.slave_valid !== 1'b0) begin errors++; $display("FAIL reset_rr_valid: got %b want 0", r_bus.slave_valid); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_scan();
      f_set_id = 1'b1; f_tag = '0; f_bus.master_valid = '1; f_bus.slave_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         f_scan_in = IDW'(7 - k);
         @(negedge clk);
         checks++; if (f_bus.master_ready !== 8'h00) begin errors++; $display("FAIL scan_ready_low: got %b want 00000000", f_bus.master_ready); end
         if (k == 7) begin
            checks++; if (f_scan_out !== 4'd0) begin errors++; $display("FAIL scan_out_early: got %0d want 0", f_scan_out); end
         end
         step();
      end
      f_set_id = 1'b0; f_bus.master_valid = '0;
      @(negedge clk);
      checks++; if (f_scan_out !== 4'd7) begin errors++; $display("FAIL scan_out: got %0d want 7", f_scan_out); end
      for (int i = 0; i < 8; i++) f_bus.master_data[i*DW +: DW] = 16'(16'hA000 + i);
      for (int t = 0; t < 8; t++) begin
         f_tag = IDW'(t); f_bus.master_valid = '1;
         @(negedge clk);
         checks++; if (f_bus.master_ready !== 8'hFF) begin errors++; $display("FAIL scan_id_ready t=%0d: got %b want 11111111", t, f_bus.master_ready); end
         step();
         f_bus.master_valid = '0;
         @(negedge clk);
         checks++;
         if (f_bus.slave_valid !== 1'b1 || f_bus.slave_data !== 16'(16'hA000 + t)) begin
            errors++; $display("FAIL scan_id_data t=%0d: got v=%b d=%h want v=1 d=%h", t, f_bus.slave_valid, f_bus.slave_data, 16'(16'hA000 + t));
         end
         step();
      end
   endtask

   task automatic test_fixed_priority();
      logic [7:0] pend, g, exp_g;
      logic [DW-1:0] exp_d;
      logic prev_x;
      f_set_id = 1'b1; f_scan_in = 4'd3;
      repeat (8) step();
      f_set_id = 1'b0; f_tag = 4'd3; f_bus.slave_ready = 1'b1;
      for (int i = 0; i < 8; i++) f_bus.master_data[i*DW +: DW] = 16'(16'hB000 + i);
      sb.delete();
      sb.push_back(16'hB002); sb.push_back(16'hB005); sb.push_back(16'hB007);
      pend = 8'b1010_0100;
      f_bus.master_valid = pend;
      prev_x = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         g = f_bus.master_valid & f_bus.master_ready;
         exp_g = pend & (~pend + 8'd1);
         checks++; if (g !== exp_g) begin errors++; $display("FAIL fixed_grant c=%0d: got %b want %b", c, g, exp_g); end
         checks++; if (f_bus.slave_valid !== prev_x) begin errors++; $display("FAIL fixed_latency c=%0d: got %b want %b", c, f_bus.slave_valid, prev_x); end
         if (f_bus.slave_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL fixed_extra_beat: got %h want none", f_bus.slave_data); end
            else begin
               exp_d = sb.pop_front();
               if (f_bus.slave_data !== exp_d) begin errors++; $display("FAIL fixed_data: got %h want %h", f_bus.slave_data, exp_d); end
            end
         end
         prev_x = (exp_g != 8'h00);
         step();
         pend &= ~g;
         f_bus.master_valid = pend;
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL fixed_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_drop();
      f_tag = 4'd5; f_bus.slave_ready = 1'b1; f_bus.master_valid = 8'b0000_0010;
      @(negedge clk);
      checks++; if (f_bus.master_ready !== 8'hFF) begin errors++; $display("FAIL drop_ready: got %b want 11111111", f_bus.master_ready); end
      step();
      f_bus.master_valid = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (f_bus.slave_valid !== 1'b0) begin errors++; $display("FAIL drop_valid c=%0d: got %b want 0", c, f_bus.slave_valid); end
         step();
      end
   endtask

   task automatic test_set_id_hold();
      logic [DW-1:0] exp_d;
      f_tag = 4'd3; f_bus.slave_ready = 1'b0; f_bus.master_valid = 8'h01;
      f_bus.master_data[0 +: DW] = 16'hB100;
      @(negedge clk);
      checks++; if (f_bus.master_ready !== 8'h01) begin errors++; $display("FAIL setid_pre_ready: got %b want 00000001", f_bus.master_ready); end
      sb.push_back(16'hB100);
      step();
      f_bus.master_valid = '1; f_set_id = 1'b1; f_scan_in = 4'd3;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (f_bus.master_ready !== 8'h00) begin errors++; $display("FAIL setid_ready c=%0d: got %b want 00000000", c, f_bus.master_ready); end
         checks++;
         if (f_bus.slave_valid !== 1'b1 || f_bus.slave_data !== sb[0]) begin
            errors++; $display("FAIL setid_hold c=%0d: got v=%b d=%h want v=1 d=%h", c, f_bus.slave_valid, f_bus.slave_data, sb[0]);
         end
         step();
      end
      f_bus.slave_ready = 1'b1;
      @(negedge clk);
      exp_d = sb.pop_front();
      checks++;
      if (f_bus.slave_valid !== 1'b1 || f_bus.slave_data !== exp_d) begin
         errors++; $display("FAIL setid_drain: got v=%b d=%h want v=1 d=%h", f_bus.slave_valid, f_bus.slave_data, exp_d);
      end
      step();
      @(negedge clk);
      checks++; if (f_bus.slave_valid !== 1'b0) begin errors++; $display("FAIL setid_no_grant: got %b want 0", f_bus.slave_valid); end
      f_set_id = 1'b0; f_bus.master_valid = '0;
      step();
   endtask

   task automatic test_round_robin();
      bit pat [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int cnt [4] = '{0, 0, 0, 0};
      int mptr = 0;
      int gi;
      bit mfull = 1'b0;
      bit acc;
      logic [3:0] g, exp_g;
      r_tag = '0;
      sb.delete();
      for (int c = 0; c < 12; c++) begin
         r_bus.slave_ready  = (c < 10) ? pat[c] : 1'b1;
         r_bus.master_valid = (c < 10) ? 4'hF : 4'h0;
         for (int i = 0; i < 4; i++) r_bus.master_data[i*DW +: DW] = 16'((i << 12) | cnt[i]);
         @(negedge clk);
         g = r_bus.master_valid & r_bus.master_ready;
         acc = !mfull || r_bus.slave_ready;
         gi = -1;
         if (acc)
            for (int k = 0; k < 4; k++)
               if (gi < 0 && r_bus.master_valid[(mptr + k) % 4]) gi = (mptr + k) % 4;
         exp_g = '0;
         if (gi >= 0) exp_g[gi] = 1'b1;
         checks++; if (g !== exp_g) begin errors++; $display("FAIL rr_grant c=%0d: got %b want %b", c, g, exp_g); end
         checks++; if (r_bus.slave_valid !== mfull) begin errors++; $display("FAIL rr_valid c=%0d: got %b want %b", c, r_bus.slave_valid, mfull); end
         if (r_bus.slave_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL rr_extra_beat c=%0d: got %h want none", c, r_bus.slave_data); end
            else begin
               if (r_bus.slave_data !== sb[0]) begin errors++; $display("FAIL rr_data c=%0d: got %h want %h", c, r_bus.slave_data, sb[0]); end
               if (r_bus.slave_ready) void'(sb.pop_front());
            end
         end
         if (gi >= 0) begin
            sb.push_back(16'((gi << 12) | cnt[gi]));
            cnt[gi]++;
            mptr = (gi + 1) % 4;
         end
         mfull = (gi >= 0) || (mfull && !r_bus.slave_ready);
         step();
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rr_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_comb_passthrough();
      c_tag = '0;
      for (int i = 0; i < 4; i++) c_bus.master_data[i*DW +: DW] = 16'(16'hD000 + i);
      c_bus.master_valid = 4'b0110; c_bus.slave_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (c_bus.slave_valid !== 1'b1 || c_bus.slave_data !== 16'hD001 || c_bus.master_ready !== 4'b0000) begin
         errors++; $display("FAIL comb_stall: got v=%b d=%h r=%b want v=1 d=d001 r=0000", c_bus.slave_valid, c_bus.slave_data, c_bus.master_ready);
      end
      c_bus.slave_ready = 1'b1;
      #1;
      checks++;
      if (c_bus.master_ready !== 4'b0010 || c_bus.slave_data !== 16'hD001) begin
         errors++; $display("FAIL comb_first: got d=%h r=%b want d=d001 r=0010", c_bus.slave_data, c_bus.master_ready);
      end
      step();
      @(negedge clk);
      checks++;
      if (c_bus.master_ready !== 4'b0100 || c_bus.slave_data !== 16'hD002) begin
         errors++; $display("FAIL comb_rr_next: got d=%h r=%b want d=d002 r=0100", c_bus.slave_data, c_bus.master_ready);
      end
      c_bus.master_valid = 4'b0000;
      #1;
      checks++;
      if (c_bus.slave_valid !== 1'b0 || c_bus.slave_data !== 16'h0000) begin
         errors++; $display("FAIL comb_idle: got v=%b d=%h want v=0 d=0000", c_bus.slave_valid, c_bus.slave_data);
      end
      c_tag = 4'd1; c_bus.master_valid = 4'hF;
      #1;
      checks++;
      if (c_bus.master_ready !== 4'hF || c_bus.slave_valid !== 1'b0) begin
         errors++; $display("FAIL comb_tag_change: got v=%b r=%b want v=0 r=1111", c_bus.slave_valid, c_bus.master_ready);
      end
      c_bus.master_valid = '0; c_tag = '0;
      step();
   endtask

   task automatic test_reset_mid_transfer();
      f_tag = 4'd3; f_bus.slave_ready = 1'b0; f_bus.master_valid = 8'h10;
      f_bus.master_data[4*DW +: DW] = 16'hC004;
      step();
      f_bus.master_valid = '0;
      @(negedge clk);
      checks++; if (f_bus.slave_valid !== 1'b1) begin errors++; $display("FAIL rstmid_full: got %b want 1", f_bus.slave_valid); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (f_bus.slave_valid !== 1'b0 || f_bus.slave_data !== '0) begin
         errors++; $display("FAIL rstmid_async: got v=%b d=%h want v=0 d=0000", f_bus.slave_valid, f_bus.slave_data);
      end
      checks++; if (f_scan_out !== '0) begin errors++; $display("FAIL rstmid_scan_out: got %h want 0", f_scan_out); end
      @(negedge clk);
      rst = 1'b1;
      f_tag = '0; f_bus.master_valid = 8'h10; f_bus.slave_ready = 1'b1;
      r_tag = '0; r_bus.master_valid = 4'hF; r_bus.slave_ready = 1'b1;
      #1;
      checks++; if (r_bus.master_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_rr_ptr: got %b want 0001", r_bus.master_ready); end
      step();
      f_bus.master_valid = '0; r_bus.master_valid = '0;
      @(negedge clk);
      checks++;
      if (f_bus.slave_valid !== 1'b1 || f_bus.slave_data !== 16'hC004) begin
         errors++; $display("FAIL rstmid_ids_zero: got v=%b d=%h want v=1 d=c004", f_bus.slave_valid, f_bus.slave_data);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_scan();
      test_fixed_priority();
      test_drop();
      test_set_id_hold();
      test_round_robin();
      test_comb_passthrough();
      test_reset_mid_transfer();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
